ro_puf_reader: RTL
==================

// Module: ro_puf_reader
// PURPOSE
//   Measurement end of the two-bit ring-oscillator PUF.
//   - Enables NUM_RO oscillator cells and counts rising edges of each cell output over a fixed window of clk cycles.
//   - Compares counts pairwise (RO 2i vs 2i+1) to form one response bit per pair.
//   - Sits between the RO cell array and the challenge/response controller.
// PARAMETERS
//   NUM_RO     4     number of oscillator inputs; even, >=2
//   CNT_W      16    width of each edge counter
//   SETTLE_CYC 16    cycles with ro_en high before counting starts (>=1)
//   WINDOW     1024  counting window in clk cycles (>=1, < 2**32)
// PORTS
//   clk         in   1          single system clock
//   rst         in   1          synchronous, active-high reset
//   start       in   1          1-cycle pulse; begins a measurement when IDLE
//   busy        out  1          high in SETTLE/COUNT/DRAIN/COMPARE/DONE
//   ro_en       out  NUM_RO     enable to every oscillator cell; all bits equal
//   ro_out      in   NUM_RO     raw asynchronous oscillator outputs
//   resp        out  NUM_RO/2   bit i = 1 iff cnt[2i] > cnt[2i+1]
//   resp_tie    out  NUM_RO/2   bit i = 1 iff cnt[2i] == cnt[2i+1]
//   resp_sat    out  1          any counter saturated during the window
//   resp_valid  out  1          response held valid until accepted
//   resp_ready  in   1          consumer accepts when resp_valid & resp_ready
// BEHAVIOUR
//   Reset (rst=1 at posedge clk):
//     - state=IDLE; ro_en=0, busy=0, resp_valid=0.
//     - resp=0, resp_tie=0, resp_sat=0; all counters, sync flops and timers cleared.
//     - Reset mid-measurement aborts it; no partial response is ever presented.
//   Input path per ro_out bit:
//     - 2-flop synchronizer, then 1 flop for edge detect.
//     - Rising-edge pulse rise[i] occurs 3 cycles after the sampled 0->1.
//   FSM:
//     - IDLE: start=1 -> SETTLE; counters cleared; ro_en=1 next cycle. start while busy is ignored.
//     - SETTLE: ro_en=1 for SETTLE_CYC cycles; rise pulses ignored; then -> COUNT.
//     - COUNT: for exactly WINDOW cycles, each rise[i] increments cnt[i]; then -> DRAIN.
//     - DRAIN: 3 cycles; ro_en already 0, count gating closed.
//       Edges still in the sync pipe are NOT counted, so window length is exact. Then -> COMPARE.
//     - COMPARE: 1 cycle; register resp, resp_tie, resp_sat; -> DONE.
//     - DONE: resp_valid=1; outputs stable; on resp_valid & resp_ready -> IDLE, resp_valid=0 next cycle.
//       start during DONE is ignored.
//   ro_en: 1 from first SETTLE cycle through last COUNT cycle, 0 otherwise.
//   Counters: saturate at 2**CNT_W-1 (no wrap); saturation sets sticky resp_sat.
//     - Compare is unsigned, on saturated values.
//     - Tie: resp bit = 0, resp_tie bit = 1.
//   Latency: start -> resp_valid = 1 + SETTLE_CYC + WINDOW + 3 + 1 cycles (1 cycle into SETTLE; resp_valid high in first DONE cycle).
//   Window timer width: $clog2(WINDOW+1); settle timer width: $clog2(SETTLE_CYC+1).
//   Simultaneous rst and start: rst wins.
// STRUCTURE
//   Package ro_puf_pkg:
//     - state enum {IDLE, SETTLE, COUNT, DRAIN, COMPARE, DONE}
//     - SYNC_STAGES=2, DRAIN_CYC=3
//   Sub-module ro_edge_counter, instantiated NUM_RO times:
//     - ports clk, rst, clr, cnt_en, ro_in; outputs cnt[CNT_W], sat
//     - contains synchronizer, edge detect, saturating counter
//   Top: FSM, timers, pairwise comparators.
// TESTING
//   1. ro0 rises every 4 clk, ro1 every 6 clk, WINDOW=1024
//      -> cnt 256/170 (+/-1), resp[0]=1, tie[0]=0, sat=0.
//   2. ro2 and ro3 same waveform, same phase -> resp[1]=0, resp_tie[1]=1.
//   3. CNT_W=4, ro0 rises every 2 clk
//      -> cnt0 stops at 15, resp_sat=1, no wrap.
//   4. rst in middle of COUNT
//      -> next cycle ro_en=0, busy=0, resp_valid=0.
//      -> fresh start yields a correct full result.
//   5. resp_ready held 0 for 50 cycles in DONE, start pulsed twice
//      -> resp stable, no new run; ready=1 -> IDLE.
//   6. Edges only in SETTLE and DRAIN, none in COUNT
//      -> all counts 0, all resp_tie=1; latency equals formula.

Source files
------------

// File: rtl/ro_puf_pkg.sv
// Shared types and constants for the ring-oscillator PUF reader.
// Holds the FSM encoding and the fixed input-pipeline depths.
package ro_puf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    COUNT,
    DRAIN,
    COMPARE,
    DONE
  } state_t;

  localparam int SYNC_STAGES = 2;
  localparam int DRAIN_CYC   = 3;

endpackage

// File: rtl/ro_puf_reader_counter.sv
// One oscillator lane: synchronizer, rising-edge detect and a
// saturating edge counter with a sticky saturation flag.
module ro_edge_counter
  import ro_puf_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             cnt_en,
  input  logic             ro_in,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_last;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_sat;
  logic                   w_rise;

  assign w_rise = r_sync[SYNC_STAGES-1] & ~r_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_last <= 1'b0;
      r_cnt  <= '0;
      r_sat  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], ro_in};
      r_last <= r_sync[SYNC_STAGES-1];
      if (clr) begin
        r_cnt <= '0;
        r_sat <= 1'b0;
      end else if (cnt_en && w_rise && r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
        // Flag as soon as the rail is reached; the count never wraps.
        if (r_cnt == CNT_MAX - 1'b1)
          r_sat <= 1'b1;
      end
    end
  end

  assign cnt = r_cnt;
  assign sat = r_sat;

endmodule

// File: rtl/ro_puf_reader.sv
// RO PUF measurement: enables the oscillators, counts edges over a
// fixed window and compares lanes pairwise into response bits.
module ro_puf_reader
  import ro_puf_pkg::*;
#(
  parameter int NUM_RO     = 4,
  parameter int CNT_W      = 16,
  parameter int SETTLE_CYC = 16,
  parameter int WINDOW     = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic [NUM_RO-1:0]   ro_en,
  input  logic [NUM_RO-1:0]   ro_out,
  output logic [NUM_RO/2-1:0] resp,
  output logic [NUM_RO/2-1:0] resp_tie,
  output logic                resp_sat,
  output logic                resp_valid,
  input  logic                resp_ready
);

  localparam int NP    = NUM_RO / 2;
  localparam int ST_W  = $clog2(SETTLE_CYC + 1);
  localparam int WIN_W = $clog2(WINDOW + 1);

  localparam logic [ST_W-1:0]  ST_LAST  = ST_W'(SETTLE_CYC - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [1:0]       DR_LAST  = 2'(DRAIN_CYC - 1);

  state_t           r_state;
  logic [ST_W-1:0]  r_set;
  logic [WIN_W-1:0] r_win;
  logic [1:0]       r_drn;
  logic             r_en;
  logic             r_busy;
  logic             r_valid;
  logic [NP-1:0]    r_resp;
  logic [NP-1:0]    r_tie;
  logic             r_sat;

  logic             w_clr;
  logic             w_cnt_en;
  logic [CNT_W-1:0] w_cnt [NUM_RO];
  logic [NUM_RO-1:0] w_sat;
  logic [NP-1:0]    w_gt;
  logic [NP-1:0]    w_eq;

  assign w_clr    = (r_state == IDLE) && start;
  assign w_cnt_en = (r_state == COUNT);

  for (genvar g = 0; g < NUM_RO; g++) begin : g_lane
    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (w_clr),
      .cnt_en (w_cnt_en),
      .ro_in  (ro_out[g]),
      .cnt    (w_cnt[g]),
      .sat    (w_sat[g])
    );
  end

  always_comb begin
    w_gt = '0;
    w_eq = '0;
    for (int p = 0; p < NP; p++) begin
      w_gt[p] = w_cnt[2*p] > w_cnt[2*p+1];
      w_eq[p] = w_cnt[2*p] == w_cnt[2*p+1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_set   <= '0;
      r_win   <= '0;
      r_drn   <= '0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_resp  <= '0;
      r_tie   <= '0;
      r_sat   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= SETTLE;
            r_set   <= '0;
            r_en    <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        SETTLE: begin
          if (r_set == ST_LAST) begin
            r_state <= COUNT;
            r_win   <= '0;
          end else begin
            r_set <= r_set + 1'b1;
          end
        end
        COUNT: begin
          if (r_win == WIN_LAST) begin
            r_state <= DRAIN;
            r_drn   <= '0;
            r_en    <= 1'b0;
          end else begin
            r_win <= r_win + 1'b1;
          end
        end
        // Let in-flight synchronizer edges fall out uncounted.
        DRAIN: begin
          if (r_drn == DR_LAST)
            r_state <= COMPARE;
          else
            r_drn <= r_drn + 1'b1;
        end
        COMPARE: begin
          r_resp  <= w_gt;
          r_tie   <= w_eq;
          r_sat   <= |w_sat;
          r_valid <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          if (resp_ready) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign ro_en      = {NUM_RO{r_en}};
  assign resp       = r_resp;
  assign resp_tie   = r_tie;
  assign resp_sat   = r_sat;
  assign resp_valid = r_valid;

endmodule
